// File: rtl/sine_analyzer.sv
// rtl/sine_analyzer.sv - rising zero-crossing period and peak analyzer with hysteresis
// Measures period, signed peaks, peak-to-peak and lock per waveform period.
module sine_analyzer #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16,
  parameter int HYST   = 4,
  parameter int TOL    = 1
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     din_valid,
  input  logic signed [DATA_W-1:0] din,
  output logic                     meas_valid,
  output logic [CNT_W-1:0]         period,
  output logic signed [DATA_W-1:0] pk_max,
  output logic signed [DATA_W-1:0] pk_min,
  output logic [DATA_W:0]          pk_pk,
  output logic                     locked,
  output logic                     timeout
);

  typedef enum logic {S_SEARCH = 1'b0, S_MEASURE = 1'b1} state_t;

  localparam logic signed [DATA_W-1:0] L_NEG_HYST = $signed(DATA_W'(-HYST));
  localparam logic [CNT_W-1:0]         L_CNT_TO   = {{(CNT_W-1){1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0]         L_TOL      = CNT_W'(TOL);
  localparam logic signed [DATA_W-1:0] L_MAX_INIT = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] L_MIN_INIT = {1'b0, {(DATA_W-1){1'b1}}};

  state_t                     r_state;
  logic                       r_armed;
  logic                       r_have_prev;
  logic [CNT_W-1:0]           r_cnt;
  logic signed [DATA_W-1:0]   r_run_max;
  logic signed [DATA_W-1:0]   r_run_min;
  logic                       r_meas_valid;
  logic [CNT_W-1:0]           r_period;
  logic signed [DATA_W-1:0]   r_pk_max;
  logic signed [DATA_W-1:0]   r_pk_min;
  logic [DATA_W:0]            r_pk_pk;
  logic                       r_locked;
  logic                       r_timeout;

  logic                       w_below;
  logic                       w_x;
  logic [CNT_W-1:0]           w_period_new;
  logic [CNT_W-1:0]           w_absdiff;
  logic [DATA_W:0]            w_pkpk;
  logic signed [DATA_W-1:0]   w_next_max;
  logic signed [DATA_W-1:0]   w_next_min;

  assign w_below      = (din < L_NEG_HYST);
  assign w_x          = r_armed && !din[DATA_W-1];
  assign w_period_new = r_cnt + 1'b1;
  assign w_absdiff    = (w_period_new >= r_period) ? (w_period_new - r_period)
                                                   : (r_period - w_period_new);
  // One extra bit keeps the signed difference from wrapping (e.g. 127 - -128).
  assign w_pkpk       = {r_run_max[DATA_W-1], r_run_max} - {r_run_min[DATA_W-1], r_run_min};
  assign w_next_max   = (din > r_run_max) ? din : r_run_max;
  assign w_next_min   = (din < r_run_min) ? din : r_run_min;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      r_state      <= S_SEARCH;
      r_armed      <= 1'b0;
      r_have_prev  <= 1'b0;
      r_cnt        <= '0;
      r_run_max    <= L_MAX_INIT;
      r_run_min    <= L_MIN_INIT;
      r_meas_valid <= 1'b0;
      r_period     <= '0;
      r_pk_max     <= '0;
      r_pk_min     <= '0;
      r_pk_pk      <= '0;
      r_locked     <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_meas_valid <= 1'b0;
      r_timeout    <= 1'b0;
      if (din_valid) begin
        if (w_x) begin
          r_armed <= 1'b0;
        end else if (w_below) begin
          r_armed <= 1'b1;
        end
        case (r_state)
          S_SEARCH: begin
            if (w_x) begin
              r_state     <= S_MEASURE;
              r_cnt       <= '0;
              r_run_max   <= din;
              r_run_min   <= din;
              r_have_prev <= 1'b0;
            end
          end
          S_MEASURE: begin
            if (w_x) begin
              r_period     <= w_period_new;
              r_pk_max     <= r_run_max;
              r_pk_min     <= r_run_min;
              r_pk_pk      <= w_pkpk;
              r_meas_valid <= 1'b1;
              r_locked     <= r_have_prev && (w_absdiff <= L_TOL);
              r_have_prev  <= 1'b1;
              r_cnt        <= '0;
              r_run_max    <= din;
              r_run_min    <= din;
            end else if (r_cnt == L_CNT_TO) begin
              // Saturated without a crossing: drop lock and re-acquire from scratch.
              r_timeout <= 1'b1;
              r_locked  <= 1'b0;
              r_state   <= S_SEARCH;
              r_armed   <= 1'b0;
            end else begin
              r_cnt     <= r_cnt + 1'b1;
              r_run_max <= w_next_max;
              r_run_min <= w_next_min;
            end
          end
          default: r_state <= S_SEARCH;
        endcase
      end
    end
  end

  assign meas_valid = r_meas_valid;
  assign period     = r_period;
  assign pk_max     = r_pk_max;
  assign pk_min     = r_pk_min;
  assign pk_pk      = r_pk_pk;
  assign locked     = r_locked;
  assign timeout    = r_timeout;

endmodule
